// File: rtl/rtc_bus_cycle_gen_if.sv
// Strobe/flag bundle between the RTC sequencer (master) and the bus-cycle engine (slave).
// Read-capture signals exist only when RTC_RD_CAPTURE_EN is defined.
interface rtc_bus_cycle_gen_if;
  logic do_it;
  logic w_r;
  logic a_d;
  logic cs;
  logic rd;
  logic wr;
  logic send_add;
  logic send_data;
  logic read_data;
  logic txn_done;
  logic busy;
`ifdef RTC_RD_CAPTURE_EN
  logic [7:0] dat_in;
  logic [7:0] dat_leido;
  logic       rd_valid;

  modport master (
    output do_it, w_r, dat_in,
    input  a_d, cs, rd, wr, send_add, send_data, read_data, txn_done, busy, dat_leido, rd_valid
  );
  modport slave (
    input  do_it, w_r, dat_in,
    output a_d, cs, rd, wr, send_add, send_data, read_data, txn_done, busy, dat_leido, rd_valid
  );
`else
  modport master (
    output do_it, w_r,
    input  a_d, cs, rd, wr, send_add, send_data, read_data, txn_done, busy
  );
  modport slave (
    input  do_it, w_r,
    output a_d, cs, rd, wr, send_add, send_data, read_data, txn_done, busy
  );
`endif
endinterface

// File: rtl/rtc_bus_cycle_gen.sv
// Bus-cycle engine for the muxed A/D RTC port; outputs registered, cs falls 1 cycle after do_it.
// No backpressure: do_it is a level sampled at txn boundaries. Optional read capture: RTC_RD_CAPTURE_EN.
module rtc_bus_cycle_gen #(
  parameter int unsigned T_ADR = 10,
  parameter int unsigned T_GAP = 11,
  parameter int unsigned T_DAT = 10,
  parameter int unsigned T_REC = 12
) (
  input logic               clk,
  input logic               reset,
  rtc_bus_cycle_gen_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_ADR, S_GAP, S_DAT, S_REC} state_e;

  localparam logic [7:0] ADR_LAST = 8'(T_ADR - 1);
  localparam logic [7:0] GAP_LAST = 8'(T_GAP - 1);
  localparam logic [7:0] DAT_LAST = 8'(T_DAT - 1);
  localparam logic [7:0] REC_LAST = 8'(T_REC - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wr_q, wr_d;

  logic a_d_q, a_d_d;
  logic cs_q, cs_d;
  logic rd_q, rd_d;
  logic wr_n_q, wr_n_d;
  logic send_add_q, send_add_d;
  logic send_data_q, send_data_d;
  logic read_data_q, read_data_d;
  logic txn_done_q, txn_done_d;
  logic busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    wr_d    = wr_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.do_it) begin
          state_d = S_ADR;
          wr_d    = bus.w_r;
        end
      end
      S_ADR: if (cnt_q == ADR_LAST) begin
        state_d = S_GAP;
        cnt_d   = '0;
      end
      S_GAP: if (cnt_q == GAP_LAST) begin
        state_d = S_DAT;
        cnt_d   = '0;
      end
      S_DAT: if (cnt_q == DAT_LAST) begin
        state_d = S_REC;
        cnt_d   = '0;
      end
      S_REC: if (cnt_q == REC_LAST) begin
        cnt_d = '0;
        // Back-to-back: skip IDLE so the period is exactly one transaction.
        if (bus.do_it) begin
          state_d = S_ADR;
          wr_d    = bus.w_r;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from next state so they line up with the state register.
  always_comb begin
    a_d_d       = 1'b1;
    cs_d        = 1'b1;
    rd_d        = 1'b1;
    wr_n_d      = 1'b1;
    send_add_d  = 1'b0;
    send_data_d = 1'b0;
    read_data_d = 1'b0;
    txn_done_d  = 1'b0;
    busy_d      = (state_d != S_IDLE);
    case (state_d)
      S_ADR: begin
        a_d_d      = 1'b0;
        cs_d       = 1'b0;
        wr_n_d     = 1'b0;
        send_add_d = 1'b1;
      end
      S_DAT: begin
        cs_d = 1'b0;
        if (wr_d) begin
          wr_n_d      = 1'b0;
          send_data_d = 1'b1;
        end else begin
          rd_d        = 1'b0;
          read_data_d = (cnt_d == DAT_LAST);
        end
      end
      S_REC:   txn_done_d = (cnt_d == REC_LAST);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      a_d_q       <= 1'b1;
      cs_q        <= 1'b1;
      rd_q        <= 1'b1;
      wr_n_q      <= 1'b1;
      send_add_q  <= 1'b0;
      send_data_q <= 1'b0;
      read_data_q <= 1'b0;
      txn_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      a_d_q       <= a_d_d;
      cs_q        <= cs_d;
      rd_q        <= rd_d;
      wr_n_q      <= wr_n_d;
      send_add_q  <= send_add_d;
      send_data_q <= send_data_d;
      read_data_q <= read_data_d;
      txn_done_q  <= txn_done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.a_d       = a_d_q;
  assign bus.cs        = cs_q;
  assign bus.rd        = rd_q;
  assign bus.wr        = wr_n_q;
  assign bus.send_add  = send_add_q;
  assign bus.send_data = send_data_q;
  assign bus.read_data = read_data_q;
  assign bus.txn_done  = txn_done_q;
  assign bus.busy      = busy_q;

`ifdef RTC_RD_CAPTURE_EN
  logic [7:0] dat_leido_q;
  logic       rd_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dat_leido_q <= 8'h00;
      rd_valid_q  <= 1'b0;
    end else begin
      rd_valid_q <= read_data_q;
      if (read_data_q) dat_leido_q <= bus.dat_in;
    end
  end

  assign bus.dat_leido = dat_leido_q;
  assign bus.rd_valid  = rd_valid_q;
`endif

endmodule

// File: tb/tb_rtc_bus_cycle_gen.sv
// Randomized + directed bench for rtc_bus_cycle_gen; reference model works on transaction offsets.
// Per-cycle expectations and per-transaction shapes are queued by the stimulus and checked by a monitor.
module tb_rtc_bus_cycle_gen;

  localparam int A   = 10;
  localparam int G   = 11;
  localparam int D   = 10;
  localparam int R   = 12;
  localparam int TXN = A + G + D + R;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rtc_bus_cycle_gen_if bus ();

  rtc_bus_cycle_gen #(.T_ADR(A), .T_GAP(G), .T_DAT(D), .T_REC(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // {a_d, cs, rd, wr, send_add, send_data, read_data, txn_done, busy}
  logic [8:0] exp_q[$];
  bit         txn_q[$];

  int m_off  = 0;
  bit m_kind = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [8:0] exp_vec(int off, bit kind);
    logic a_d, cs, rd, wr, sa, sd, rdd, td;
    a_d = 1; cs = 1; rd = 1; wr = 1; sa = 0; sd = 0; rdd = 0; td = 0;
    if (off >= 1 && off <= A) begin
      a_d = 0; cs = 0; wr = 0; sa = 1;
    end else if (off > A + G && off <= A + G + D) begin
      cs = 0;
      if (kind) begin
        wr = 0; sd = 1;
      end else begin
        rd = 0; rdd = (off == A + G + D);
      end
    end
    td = (off == TXN);
    return {a_d, cs, rd, wr, sa, sd, rdd, td, (off != 0)};
  endfunction

  task automatic apply(bit d, bit w, bit r);
    reset     = r;
    bus.do_it = d;
    bus.w_r   = w;
`ifdef RTC_RD_CAPTURE_EN
    bus.dat_in = 8'($urandom);
`endif
    if (r) begin
      if (m_off != 0 && m_off != TXN) void'(txn_q.pop_back());
      m_off = 0;
    end else if (m_off == 0 || m_off == TXN) begin
      if (d) begin
        m_off  = 1;
        m_kind = w;
        txn_q.push_back(w);
      end else begin
        m_off = 0;
      end
    end else begin
      m_off++;
    end
    exp_q.push_back(exp_vec(m_off, m_kind));
  endtask

  task automatic cycle(bit d, bit w, bit r);
    @(posedge clk);
    #1;
    apply(d, w, r);
  endtask

  // Monitor: compares every cycle and each completed transaction's shape.
  int n_len = 0, n_cs = 0, n_wr = 0, n_rd = 0, n_rdd = 0, n_sa = 0, n_sd = 0;
`ifdef RTC_RD_CAPTURE_EN
  logic       exp_rdv    = 1'b0;
  logic [7:0] exp_leido  = 8'h00;
`endif

  always @(negedge clk) begin
    logic [8:0] ev;
    bit         k;
    if (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      check("outputs", {bus.a_d, bus.cs, bus.rd, bus.wr, bus.send_add, bus.send_data,
                        bus.read_data, bus.txn_done, bus.busy}, ev);
      check("rd_wr_excl", {63'd0, (~bus.rd & ~bus.wr)}, 64'd0);
      check("flags_onehot0", {63'd0, ($countones({bus.send_add, bus.send_data, bus.read_data}) > 1)}, 64'd0);
`ifdef RTC_RD_CAPTURE_EN
      check("rd_valid", {63'd0, bus.rd_valid}, {63'd0, exp_rdv});
      check("dat_leido", {56'd0, bus.dat_leido}, {56'd0, exp_leido});
      if (reset) begin
        exp_rdv   = 1'b0;
        exp_leido = 8'h00;
      end else begin
        exp_rdv = ev[2];
        if (ev[2]) exp_leido = bus.dat_in;
      end
`endif
      if (bus.busy) begin
        n_len++;
        n_cs  += int'(!bus.cs);
        n_wr  += int'(!bus.wr);
        n_rd  += int'(!bus.rd);
        n_rdd += int'(bus.read_data);
        n_sa  += int'(bus.send_add);
        n_sd  += int'(bus.send_data);
      end
      if (bus.txn_done) begin
        if (txn_q.size() == 0) begin
          check("txn_unexpected", 64'd1, 64'd0);
        end else begin
          k = txn_q.pop_front();
          check("txn_shape",
                {8'(n_len), 8'(n_cs), 8'(n_wr), 8'(n_rd), 8'(n_rdd), 8'(n_sa), 8'(n_sd)},
                {8'(TXN), 8'(A + D), 8'(A + (k ? D : 0)), 8'(k ? 0 : D),
                 8'(k ? 0 : 1), 8'(A), 8'(k ? D : 0)});
        end
      end
      if (bus.txn_done || !bus.busy) begin
        n_len = 0; n_cs = 0; n_wr = 0; n_rd = 0; n_rdd = 0; n_sa = 0; n_sd = 0;
      end
    end
  end

  initial begin
    apply(0, 0, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    // Single write, do_it pulsed one cycle.
    cycle(1, 1, 0);
    repeat (50) cycle(0, 0, 0);
    // Single read.
    cycle(1, 0, 0);
    repeat (50) cycle(0, 1, 0);
    // do_it held 559 cycles: 13 back-to-back writes.
    repeat (559) cycle(1, 1, 0);
    repeat (10) cycle(0, 1, 0);
    // do_it dropped mid-transaction: no truncation, no follow-on.
    repeat (15) cycle(1, 0, 0);
    repeat (50) cycle(0, 1, 0);
    // Reset during DAT, released with do_it high.
    cycle(1, 1, 0);
    repeat (23) cycle(0, 0, 0);
    cycle(1, 1, 1);
    repeat (3) cycle(1, 0, 0);
    repeat (60) cycle(0, 0, 0);
    // Random traffic with occasional resets and w_r churn.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 399) == 0));
    end
    repeat (TXN + 2) cycle(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("txn_q_drained", 64'(txn_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
